vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator that drives the VGA text/glyph renderer and the sync pins. It divides the system clock into a pixel-rate enable, walks the horizontal and vertical counters through a full frame, and emits `x`, `y`, `valid`, `newline`, `newframe`, `hsync` and `vsync`. The renderer consumes these to index characters and glyph rows. All outputs are registered and mutually aligned.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel. Must be ≥1; 1 means `pix_en` is stuck high.
- `H_VIS`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VIS`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: active level of `hsync` and `vsync` (0 = active-low).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `pix_en`, out, 1: one-`clk` pixel strobe. All other outputs change only in the cycle after `pix_en` is high.
- `x`, out, 10: horizontal counter, 0..H_TOTAL-1.
- `y`, out, 10: vertical counter, 0..V_TOTAL-1.
- `valid`, out, 1: high when `x < H_VIS` and `y < V_VIS`.
- `newline`, out, 1: high for exactly one `clk` when `x` becomes 0.
- `newframe`, out, 1: high for exactly one `clk` when `x` and `y` both become 0.
- `hsync`, out, 1: horizontal sync, level set by `SYNC_POL`.
- `vsync`, out, 1: vertical sync, level set by `SYNC_POL`.

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525). Both must fit in 10 bits.
- Divider: counter 0..CLK_DIV-1. `pix_en` is high in the cycle the divider equals CLK_DIV-1, then the divider wraps to 0.
- Per `pix_en`:
  - `x` increments.
  - At H_TOTAL-1, `x` wraps to 0 and `y` increments.
  - At V_TOTAL-1, `y` wraps to 0.
- Sync regions:
  - `hsync` is active for H_VIS+H_FP ≤ `x` < H_VIS+H_FP+H_SYNC.
  - `vsync` is active for V_VIS+V_FP ≤ `y` < V_VIS+V_FP+V_SYNC.
  - Both are evaluated on the new counter values. Outside these regions both sit at `~SYNC_POL`.
- No state machine beyond the counters. The horizontal phases (visible, FP, SYNC, BP) are decoded combinationally from `x` and registered with it.
- `rst` assertion at any time clears the block asynchronously and takes effect immediately.
- Reset values:
  - Divider 0, internal h = H_TOTAL-1, internal v = V_TOTAL-1.
  - `x` = `y` = 0, `valid` = 0, `newline` = `newframe` = 0, `pix_en` = 0.
  - `hsync` = `vsync` = `~SYNC_POL`.
- The first `pix_en` after reset release advances the counters to (0,0). That update asserts `newline`, `newframe` and `valid` together, so the renderer always starts on a frame boundary.

## Timing
- After `rst` deasserts, the first `pix_en` occurs in `clk` cycle CLK_DIV. Cycles are counted from the first rising edge with `rst` high, starting at 1.
- Output latency is one `clk` from `pix_en`:
  - Counters and all decoded outputs update on the same edge.
  - No output is ever skewed relative to another.
- `newline` and `newframe` are one `clk` wide regardless of CLK_DIV.
  - With CLK_DIV = 1 they are still exactly one `clk`.
  - The pulse is coincident with the cycle in which `x` reads 0.
- Wrap-around:
  - At `x` = H_TOTAL-1 with `y` = V_TOTAL-1, a single `pix_en` produces `x` = 0 and `y` = 0.
  - That same update produces both pulses. `y` never shows V_TOTAL.
- `valid` falls on the update where `x` becomes H_VIS, and rises again on the update where `x` becomes 0 with `y < V_VIS`.

## Structure
- Shared package `vga_pkg`:
  - default 640x480@60 timing constants;
  - derived H_TOTAL and V_TOTAL;
  - 10-bit coordinate typedef `coord_t`.
- The renderer imports the same package.
- One sub-module: `pix_tick_gen`. It contains the divider and `pix_en`, is parameterised by CLK_DIV, and takes the same `clk` and `rst`.
- Counters and sync decode stay in `vga_timing_gen`.

## Test plan
- **Reset release:** `rst` low for 5 cycles, then high with CLK_DIV = 2.
  - Required: `pix_en` first high at cycle 2.
  - At cycle 3: `x` = 0, `y` = 0, `valid` = 1, `newline` = `newframe` = 1.
  - At cycle 4: both pulses are 0.
- **Line timing:** run one line.
  - `valid` falls when `x` = 640.
  - `hsync` is low for `x` in 656..751, exactly 96 `pix_en` strobes (192 `clk`).
  - `newline` period is 1600 `clk`.
- **Frame wrap:** observe the update after `x` = 799, `y` = 524.
  - Required: `x` = 0, `y` = 0, both pulses high.
  - `vsync` low for `y` in 490..491.
  - `newframe` period is 840000 `clk`.
- **CLK_DIV = 1:** `pix_en` is constantly high, `newline` is still a single `clk` high every 800 cycles, and `x` steps every `clk`.
- **Mid-line reset:** assert `rst` at `x` = 300, `y` = 100.
  - Outputs go to reset values in the same cycle, without waiting for an edge.
  - After release, the first update is (0,0) with `newframe` = 1.
- **SYNC_POL = 1:** `hsync` and `vsync` idle low and pulse high over the same `x`/`y` windows.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, coordinate type and
// the horizontal phase decode used by the timing generator.
package vga_pkg;

    localparam int unsigned COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    // Default 640x480@60 timing, in pixels / lines.
    localparam int unsigned H_VIS_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_VIS_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    localparam int unsigned H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        PhVis,
        PhFront,
        PhSync,
        PhBack
    } h_phase_e;

    // Classify a horizontal position given the start of each non-visible phase.
    function automatic h_phase_e h_phase(input coord_t h, input coord_t fp_start,
                                         input coord_t sync_start, input coord_t bp_start);
        h_phase_e ph;
        if (h < fp_start) begin
            ph = PhVis;
        end else if (h < sync_start) begin
            ph = PhFront;
        end else if (h < bp_start) begin
            ph = PhSync;
        end else begin
            ph = PhBack;
        end
        return ph;
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate strobe: divides clk by CLK_DIV and emits a one-clk pix_en pulse.
module pix_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic            pix_en_q, pix_en_d;

    // Divider wraps at its terminal count; the strobe is registered off that count so it
    // stays low through reset even when CLK_DIV is 1.
    always_comb begin
        div_d    = div_q + 1'b1;
        pix_en_d = 1'b0;
        if (div_q == DivLast) begin
            div_d    = '0;
            pix_en_d = 1'b1;
        end
    end

    // Divider and strobe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
        end
    end

    assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel strobe, h/v counters and registered, mutually aligned
// coordinate, blanking, line/frame pulse and sync outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_VIS    = H_VIS_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_VIS    = V_VIS_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    output logic   pix_en,
    output coord_t x,
    output coord_t y,
    output logic   valid,
    output logic   newline,
    output logic   newframe,
    output logic   hsync,
    output logic   vsync
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam coord_t HLast      = coord_t'(H_TOTAL - 1);
    localparam coord_t VLast      = coord_t'(V_TOTAL - 1);
    localparam coord_t HFpStart   = coord_t'(H_VIS);
    localparam coord_t HSyncStart = coord_t'(H_VIS + H_FP);
    localparam coord_t HBpStart   = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VVisEnd    = coord_t'(V_VIS);
    localparam coord_t VSyncStart = coord_t'(V_VIS + V_FP);
    localparam coord_t VSyncEnd   = coord_t'(V_VIS + V_FP + V_SYNC);

    logic     pix_en_w;
    coord_t   h_q, h_d;
    coord_t   v_q, v_d;
    coord_t   x_q, y_q;
    logic     valid_q, valid_d;
    logic     newline_q, newline_d;
    logic     newframe_q, newframe_d;
    logic     hsync_q, hsync_d;
    logic     vsync_q, vsync_d;
    h_phase_e phase_d;

    pix_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .pix_en(pix_en_w)
    );

    // Counter advance. h/v reset to their last values so the first strobe lands on (0,0).
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en_w) begin
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + coord_t'(1);
            end else begin
                h_d = h_q + coord_t'(1);
            end
        end
    end

    // Decode everything from the new counter values so it registers alongside them.
    always_comb begin
        phase_d    = h_phase(h_d, HFpStart, HSyncStart, HBpStart);
        valid_d    = (phase_d == PhVis) && (v_d < VVisEnd);
        hsync_d    = (phase_d == PhSync) ? SYNC_POL : ~SYNC_POL;
        vsync_d    = ((v_d >= VSyncStart) && (v_d < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        // Pulses qualify on the strobe itself so they stay one clk wide at any divide ratio.
        newline_d  = pix_en_w && (h_d == '0);
        newframe_d = pix_en_w && (h_d == '0) && (v_d == '0);
    end

    // Counter and output registers; pulses are refreshed every clk, the rest per strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q        <= HLast;
            v_q        <= VLast;
            x_q        <= '0;
            y_q        <= '0;
            valid_q    <= 1'b0;
            newline_q  <= 1'b0;
            newframe_q <= 1'b0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            newline_q  <= newline_d;
            newframe_q <= newframe_d;
            if (pix_en_w) begin
                x_q     <= h_d;
                y_q     <= v_d;
                valid_q <= valid_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
            end
        end
    end

    assign pix_en   = pix_en_w;
    assign x        = x_q;
    assign y        = y_q;
    assign valid    = valid_q;
    assign newline  = newline_q;
    assign newframe = newframe_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three instances (default 640x480 timing, a small
// CLK_DIV=1 active-high-sync raster, a small CLK_DIV=3 raster) checked every cycle against
// an arithmetic model of pixel position versus clocks since reset release.
module tb_vga_timing_gen;

    typedef struct {
        int d;
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        bit pol;
    } cfg_t;

    typedef struct {
        bit pix_en;
        int x, y;
        bit valid, nl, nf, hs, vs;
    } exp_t;

    localparam cfg_t Cfg0 = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    localparam cfg_t Cfg1 = '{1, 16, 4, 6, 6, 12, 2, 3, 3, 1'b1};
    localparam cfg_t Cfg2 = '{3, 24, 2, 4, 3, 8, 1, 2, 2, 1'b0};

    logic clk;
    logic rst0, rst1, rst2;

    logic       pe0, pe1, pe2;
    logic [9:0] x0, x1, x2, y0, y1, y2;
    logic       va0, va1, va2, nl0, nl1, nl2, nf0, nf1, nf2;
    logic       hs0, hs1, hs2, vs0, vs1, vs2;

    longint cyc0, cyc1, cyc2, tcyc;
    int     n_checks = 0;
    int     n_fail   = 0;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst(rst0), .pix_en(pe0), .x(x0), .y(y0), .valid(va0),
        .newline(nl0), .newframe(nf0), .hsync(hs0), .vsync(vs0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_VIS(12), .V_FP(2), .V_SYNC(3), .V_BP(3), .SYNC_POL(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .pix_en(pe1), .x(x1), .y(y1), .valid(va1),
        .newline(nl1), .newframe(nf1), .hsync(hs1), .vsync(vs1)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VIS(24), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
    ) u_dut2 (
        .clk(clk), .rst(rst2), .pix_en(pe2), .x(x2), .y(y2), .valid(va2),
        .newline(nl2), .newframe(nf2), .hsync(hs2), .vsync(vs2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clocks since reset release: cycle c is the interval after the c-th rising edge.
    always @(posedge clk or negedge rst0) if (!rst0) cyc0 <= 0; else cyc0 <= cyc0 + 1;
    always @(posedge clk or negedge rst1) if (!rst1) cyc1 <= 0; else cyc1 <= cyc1 + 1;
    always @(posedge clk or negedge rst2) if (!rst2) cyc2 <= 0; else cyc2 <= cyc2 + 1;
    initial tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Strobes fall on cycles D, 2D, ...; each one advances the raster by one pixel, and the
    // outputs show the pixel one cycle later. The k-th update shows pixel index k-1.
    function automatic exp_t model(input cfg_t g, input longint c);
        exp_t   e;
        longint n, p;
        int     ht, vt;
        bit     upd;
        ht       = g.hv + g.hf + g.hs + g.hb;
        vt       = g.vv + g.vf + g.vs + g.vb;
        e.pix_en = (c >= 1) && (c % g.d == 0);
        e.x      = 0;
        e.y      = 0;
        e.valid  = 1'b0;
        e.nl     = 1'b0;
        e.nf     = 1'b0;
        e.hs     = !g.pol;
        e.vs     = !g.pol;
        if (c >= 1) begin
            n = (c - 1) / g.d;
            if (n >= 1) begin
                p       = n - 1;
                e.x     = int'(p % ht);
                e.y     = int'((p / ht) % vt);
                upd     = ((c - 1) % g.d == 0);
                e.valid = (e.x < g.hv) && (e.y < g.vv);
                e.nl    = upd && (e.x == 0);
                e.nf    = e.nl && (e.y == 0);
                if (e.x >= g.hv + g.hf && e.x < g.hv + g.hf + g.hs) e.hs = g.pol;
                if (e.y >= g.vv + g.vf && e.y < g.vv + g.vf + g.vs) e.vs = g.pol;
            end
        end
        return e;
    endfunction

    task automatic check_dut(input string nm, input cfg_t g, input longint c, input logic pe,
                             input logic [9:0] x, input logic [9:0] y, input logic va,
                             input logic nl, input logic nf, input logic hs, input logic vs);
        exp_t e;
        e = model(g, c);
        check_eq({nm, ".pix_en"}, pe, e.pix_en);
        check_eq({nm, ".x"}, x, e.x);
        check_eq({nm, ".y"}, y, e.y);
        check_eq({nm, ".valid"}, va, e.valid);
        check_eq({nm, ".newline"}, nl, e.nl);
        check_eq({nm, ".newframe"}, nf, e.nf);
        check_eq({nm, ".hsync"}, hs, e.hs);
        check_eq({nm, ".vsync"}, vs, e.vs);
    endtask

    // Per-cycle model comparison for all three instances, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        check_dut("d0", Cfg0, cyc0, pe0, x0, y0, va0, nl0, nf0, hs0, vs0);
        check_dut("d1", Cfg1, cyc1, pe1, x1, y1, va1, nl1, nf1, hs1, vs1);
        check_dut("d2", Cfg2, cyc2, pe2, x2, y2, va2, nl2, nf2, hs2, vs2);
    end

    // Default timing: line period and hsync active width measured in clk.
    initial begin
        longint last_nl;
        int     hcnt;
        last_nl = -1;
        hcnt    = 0;
        forever begin
            @(negedge clk);
            if (!rst0) begin
                last_nl = -1;
                hcnt    = 0;
            end else begin
                if (hs0 == 1'b0) hcnt++;
                if (nl0) begin
                    if (last_nl >= 0) begin
                        check_eq("d0.line_period", tcyc - last_nl, 1600);
                        check_eq("d0.hsync_width", hcnt, 192);
                    end
                    last_nl = tcyc;
                    hcnt    = 0;
                end
            end
        end
    end

    // Small raster at CLK_DIV=1: line and frame periods, active-high vsync width.
    initial begin
        longint last_nl, last_nf;
        int     vcnt;
        last_nl = -1;
        last_nf = -1;
        vcnt    = 0;
        forever begin
            @(negedge clk);
            if (!rst1) begin
                last_nl = -1;
                last_nf = -1;
                vcnt    = 0;
            end else begin
                if (vs1 == 1'b1) vcnt++;
                if (nl1) begin
                    if (last_nl >= 0) check_eq("d1.line_period", tcyc - last_nl, 32);
                    last_nl = tcyc;
                end
                if (nf1) begin
                    if (last_nf >= 0) begin
                        check_eq("d1.frame_period", tcyc - last_nf, 640);
                        check_eq("d1.vsync_width", vcnt, 96);
                    end
                    last_nf = tcyc;
                    vcnt    = 0;
                end
            end
        end
    end

    initial begin
        bit found;
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        rst2 = 1'b1;

        // Reset release with CLK_DIV=2.
        @(negedge clk);
        check_eq("rel.c1_pix_en", pe0, 0);
        @(negedge clk);
        check_eq("rel.c2_pix_en", pe0, 1);
        @(negedge clk);
        check_eq("rel.c3_x", x0, 0);
        check_eq("rel.c3_y", y0, 0);
        check_eq("rel.c3_valid", va0, 1);
        check_eq("rel.c3_newline", nl0, 1);
        check_eq("rel.c3_newframe", nf0, 1);
        @(negedge clk);
        check_eq("rel.c4_newline", nl0, 0);
        check_eq("rel.c4_newframe", nf0, 0);

        repeat (5000) @(posedge clk);

        // Mid-line asynchronous reset at x=300.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (x0 == 10'd300) found = 1'b1;
        end
        check_eq("mid.found_x300", found, 1);
        #2;
        rst0 = 1'b0;
        #1;
        check_eq("mid.x", x0, 0);
        check_eq("mid.y", y0, 0);
        check_eq("mid.valid", va0, 0);
        check_eq("mid.pix_en", pe0, 0);
        check_eq("mid.hsync", hs0, 1);
        check_eq("mid.vsync", vs0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("mid.post_x", x0, 0);
        check_eq("mid.post_y", y0, 0);
        check_eq("mid.post_newframe", nf0, 1);

        // Randomly timed resets on random instances; the model resynchronises on cycle count.
        for (int k = 0; k < 6; k++) begin
            int which;
            which = int'($urandom_range(0, 2));
            repeat ($urandom_range(1, 3000)) @(posedge clk);
            @(negedge clk);
            #($urandom_range(1, 4));
            case (which)
                0:       rst0 = 1'b0;
                1:       rst1 = 1'b0;
                default: rst2 = 1'b0;
            endcase
            repeat ($urandom_range(1, 4)) @(posedge clk);
            @(negedge clk);
            #1;
            rst0 = 1'b1;
            rst1 = 1'b1;
            rst2 = 1'b1;
        end

        repeat (4000) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
